// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

  // Default datapath width and the NOP pushed to decode on fetch exceptions
  localparam int          XLEN_DEFAULT      = 32;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  // Fetch controller states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } fetch_state_e;

  // Exception cause reported alongside each instruction
  typedef enum logic [1:0] {
    EXC_NONE     = 2'd0,
    EXC_MISALIGN = 2'd1,
    EXC_ACCESS   = 2'd2,
    EXC_TIMEOUT  = 2'd3
  } fetch_exc_e;

  // Instructions are word aligned; any low address bit set is a misaligned fetch
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_timer.sv
// Saturating cycle counter for the memory response window. Shared by the
// WAIT state (timeout detection) and the DRAIN state (bounded discard).
module fetch_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_reg;

  // Count while enabled, clear has priority, hold at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != '1)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // At or beyond the last allowed cycle; >= keeps DRAIN from stalling if the
  // count already passed the limit when it was entered
  assign expired = (count_reg >= LIMIT);

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: takes a PC from the program counter, issues one memory read,
// and hands {instr, pc, exception} to decode. Covers misaligned PCs, access
// faults, response timeout and flush of an in-flight fetch.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int               XLEN           = XLEN_DEFAULT,
  parameter int               TIMEOUT_CYCLES = 16,
  parameter logic [XLEN-1:0]  NOP_INSTR      = XLEN'(NOP_INSTR_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  // PC from program counter
  input  logic [XLEN-1:0] pc_in,
  input  logic            pc_valid,
  output logic            pc_ready,
  // Instruction memory request channel
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  // Instruction memory response channel
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            imem_rsp_err,
  // Redirect
  input  logic            flush,
  // Decode interface
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [1:0]      if_exc_cause
);

  fetch_state_e    state;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q;
  fetch_exc_e      cause_q;

  logic timer_clear;
  logic timer_enable;
  logic timer_expired;
  logic pc_accept;

  // A PC is taken only in IDLE and never while a redirect is in progress
  assign pc_accept = (state == IDLE) && pc_valid && !flush;

  // The window restarts whenever memory accepts a request, whether the
  // fetch proceeds to WAIT or is being flushed straight into DRAIN
  assign timer_clear  = (state == REQ) && imem_req_ready;
  assign timer_enable = (state == WAIT) || (state == DRAIN);

  fetch_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  // Fetch controller: state plus the instruction, PC and cause registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      cause_q <= EXC_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (pc_accept) begin
            pc_q <= pc_in;
            if (is_misaligned(pc_in[1:0])) begin
              // No memory access for a misaligned PC; report it directly
              instr_q <= NOP_INSTR;
              cause_q <= EXC_MISALIGN;
              state   <= HOLD;
            end else begin
              state <= REQ;
            end
          end
        end

        REQ: begin
          if (flush) begin
            // An accepted request still owes a response, so it must be drained
            state <= imem_req_ready ? DRAIN : IDLE;
          end else if (imem_req_ready) begin
            state <= WAIT;
          end
        end

        WAIT: begin
          if (flush) begin
            // A response in the flush cycle is dropped here; nothing left to drain
            state <= imem_rsp_valid ? IDLE : DRAIN;
          end else if (imem_rsp_valid) begin
            // Response wins over a timeout landing in the same cycle
            instr_q <= imem_rsp_data;
            cause_q <= imem_rsp_err ? EXC_ACCESS : EXC_NONE;
            state   <= HOLD;
          end else if (timer_expired) begin
            instr_q <= NOP_INSTR;
            cause_q <= EXC_TIMEOUT;
            state   <= HOLD;
          end
        end

        HOLD: begin
          // Handshake and flush both end the hold; flush adds nothing else
          if (if_ready || flush) begin
            state <= IDLE;
          end
        end

        DRAIN: begin
          // Swallow the one outstanding response, or give up silently
          if (imem_rsp_valid || timer_expired) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs decode from state and registers only, except pc_ready which also
  // honours flush in the same cycle; gating with rst_n keeps it low in reset
  assign pc_ready       = rst_n && (state == IDLE) && !flush;
  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = pc_q;
  assign if_valid       = (state == HOLD);
  assign if_instr       = instr_q;
  assign if_pc          = pc_q;
  assign if_exc_cause   = cause_q;

endmodule
